// File: rtl/conv3x3_window_gen.sv
// conv3x3_window_gen: streaming 3x3 sliding-window generator with two line buffers.
// Define CONV3X3_WINDOW_COORD_EN to add out_row/out_col (top-left coordinate of the window).
module conv3x3_window_gen #(
  parameter int IMG_W = 28,
  parameter int IMG_H = 28,
  parameter int PIX_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [PIX_W-1:0] in_pix,
  input  logic             in_valid,
  input  logic             in_sof,
  output logic             in_ready,
  output logic [PIX_W-1:0] win0,
  output logic [PIX_W-1:0] win1,
  output logic [PIX_W-1:0] win2,
  output logic [PIX_W-1:0] win3,
  output logic [PIX_W-1:0] win4,
  output logic [PIX_W-1:0] win5,
  output logic [PIX_W-1:0] win6,
  output logic [PIX_W-1:0] win7,
  output logic [PIX_W-1:0] win8,
  output logic             out_valid,
  input  logic             out_ready,
`ifdef CONV3X3_WINDOW_COORD_EN
  output logic [15:0]      out_row,
  output logic [15:0]      out_col,
`endif
  output logic             frame_done
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  logic [CW-1:0] col_q, col_d, cur_col;
  logic [RW-1:0] row_q, row_d, cur_row;
  logic [PIX_W-1:0] lb1_q [IMG_W];
  logic [PIX_W-1:0] lb2_q [IMG_W];
  logic [PIX_W-1:0] win_q [9];
  logic [PIX_W-1:0] win_d [9];
  logic [PIX_W-1:0] lb1_rd, lb2_rd;
  logic out_valid_q, out_valid_d, frame_done_q, frame_done_d;
  logic accept, qual, last_col, last_row;
  assign in_ready = out_ready || !out_valid_q;
  assign accept   = in_valid && in_ready;
  // A start-of-frame pixel is forced to (0,0) whatever the counters say
  always_comb begin
    cur_col      = in_sof ? '0 : col_q;
    cur_row      = in_sof ? '0 : row_q;
    last_col     = cur_col == CW'(IMG_W - 1);
    last_row     = cur_row == RW'(IMG_H - 1);
    qual         = cur_row >= RW'(2) && cur_col >= CW'(2);
    col_d        = !accept ? col_q : last_col ? '0 : cur_col + CW'(1);
    row_d        = !accept ? row_q : !last_col ? cur_row : last_row ? '0 : cur_row + RW'(1);
    out_valid_d  = accept ? qual : out_valid_q && !out_ready;
    frame_done_d = accept && last_col && last_row;
    lb1_rd       = lb1_q[cur_col];
    lb2_rd       = lb2_q[cur_col];
  end
  // Window shifts left; the new right column is {row r-2, row r-1, current pixel}
  always_comb begin
    win_d = win_q;
    if (accept) begin
      win_d[0] = win_q[1];
      win_d[1] = win_q[2];
      win_d[2] = lb2_rd;
      win_d[3] = win_q[4];
      win_d[4] = win_q[5];
      win_d[5] = lb1_rd;
      win_d[6] = win_q[7];
      win_d[7] = win_q[8];
      win_d[8] = in_pix;
    end
  end
  always_ff @(posedge clk) begin
    if (accept) begin
      lb2_q[cur_col] <= lb1_rd;
      lb1_q[cur_col] <= in_pix;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q        <= '0;
      row_q        <= '0;
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      win_q        <= '{default: '0};
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      out_valid_q  <= out_valid_d;
      frame_done_q <= frame_done_d;
      win_q        <= win_d;
    end
  end
`ifdef CONV3X3_WINDOW_COORD_EN
  logic [15:0] out_row_q, out_row_d, out_col_q, out_col_d;
  always_comb begin
    out_row_d = accept && qual ? 16'(cur_row - RW'(2)) : out_row_q;
    out_col_d = accept && qual ? 16'(cur_col - CW'(2)) : out_col_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_row_q <= '0;
      out_col_q <= '0;
    end else begin
      out_row_q <= out_row_d;
      out_col_q <= out_col_d;
    end
  end
  assign out_row = out_row_q;
  assign out_col = out_col_q;
`endif
  assign out_valid  = out_valid_q;
  assign frame_done = frame_done_q;
  assign win0 = win_q[0];
  assign win1 = win_q[1];
  assign win2 = win_q[2];
  assign win3 = win_q[3];
  assign win4 = win_q[4];
  assign win5 = win_q[5];
  assign win6 = win_q[6];
  assign win7 = win_q[7];
  assign win8 = win_q[8];
endmodule

// File: tb/tb_conv3x3_window_gen.sv
// tb_conv3x3_window_gen: table-driven check of the 3x3 window generator on a 4x4 image.
module tb_conv3x3_window_gen;
  typedef struct {
    logic sof;
    logic ev;
    logic fd;
    int   wr;
    int   wc;
  } vec_t;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] in_pix = '0;
  logic       in_valid = 1'b0;
  logic       in_sof = 1'b0;
  logic       out_ready = 1'b1;
  logic       in_ready, out_valid, frame_done;
  logic [7:0] win [9];
`ifdef CONV3X3_WINDOW_COORD_EN
  logic [15:0] out_row, out_col;
`endif
  vec_t tbl [16];
  int ncmp = 0;
  int nerr = 0;
  int nx = 0;
  int n0;
  always #5 clk = ~clk;
  conv3x3_window_gen #(.IMG_W(4), .IMG_H(4), .PIX_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_pix(in_pix), .in_valid(in_valid), .in_sof(in_sof),
    .in_ready(in_ready),
    .win0(win[0]), .win1(win[1]), .win2(win[2]), .win3(win[3]), .win4(win[4]),
    .win5(win[5]), .win6(win[6]), .win7(win[7]), .win8(win[8]),
    .out_valid(out_valid), .out_ready(out_ready),
`ifdef CONV3X3_WINDOW_COORD_EN
    .out_row(out_row), .out_col(out_col),
`endif
    .frame_done(frame_done)
  );
  always @(posedge clk) if (out_valid && out_ready) nx <= nx + 1;
  task automatic chk(input string name, input int act, input int exp);
    ncmp++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic chk_win(input string tag, input int base, input int wr, input int wc);
    for (int k = 0; k < 9; k++)
      chk($sformatf("%s win%0d", tag, k), int'(win[k]), base + (wr + k / 3) * 4 + wc + k % 3);
`ifdef CONV3X3_WINDOW_COORD_EN
    chk($sformatf("%s out_row", tag), int'(out_row), wr);
    chk($sformatf("%s out_col", tag), int'(out_col), wc);
`endif
  endtask
  task automatic apply(input int i, input int base);
    in_valid  = 1'b1;
    in_pix    = 8'(base + i);
    in_sof    = tbl[i].sof;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk($sformatf("out_valid p%0d", base + i), int'(out_valid), int'(tbl[i].ev));
    chk($sformatf("frame_done p%0d", base + i), int'(frame_done), int'(tbl[i].fd));
    if (tbl[i].ev) chk_win($sformatf("p%0d", base + i), base, tbl[i].wr, tbl[i].wc);
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask
  task automatic run_frame(input int base);
    for (int i = 0; i < 16; i++) apply(i, base);
  endtask
  task automatic idle(input string tag);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk({tag, " idle out_valid"}, int'(out_valid), 0);
    chk({tag, " idle frame_done"}, int'(frame_done), 0);
  endtask
  initial begin
    //           sof   ev    fd    wr wc
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 0, 0};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 0, 0};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 0, 0};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 0, 0};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 0, 0};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 0, 0};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 0, 0};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 0, 0};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 0, 0};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 0, 0};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 0, 0};
    tbl[11] = '{1'b0, 1'b1, 1'b0, 0, 1};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 0, 0};
    tbl[13] = '{1'b0, 1'b0, 1'b0, 0, 0};
    tbl[14] = '{1'b0, 1'b1, 1'b0, 1, 0};
    tbl[15] = '{1'b0, 1'b1, 1'b1, 1, 1};
    repeat (2) @(posedge clk);
    #1;
    chk("reset out_valid", int'(out_valid), 0);
    chk("reset frame_done", int'(frame_done), 0);
    chk("reset in_ready", int'(in_ready), 1);
    chk("reset win4", int'(win[4]), 0);
    rst_n = 1'b1;
    // plain frame
    n0 = nx;
    run_frame(0);
    idle("s1");
    chk("s1 transfers", nx - n0, 4);
    // backpressure on the first window
    n0 = nx;
    for (int i = 0; i < 11; i++) apply(i, 0);
    for (int s = 0; s < 3; s++) begin
      in_valid  = 1'b1;
      in_pix    = 8'd11;
      out_ready = 1'b0;
      @(posedge clk); #1;
      chk($sformatf("stall%0d out_valid", s), int'(out_valid), 1);
      chk($sformatf("stall%0d in_ready", s), int'(in_ready), 0);
      chk_win($sformatf("stall%0d", s), 0, 0, 0);
    end
    for (int i = 11; i < 16; i++) apply(i, 0);
    idle("s2");
    chk("s2 transfers", nx - n0, 4);
    // back-to-back frames
    run_frame(0);
    run_frame(100);
    idle("s3");
    // sof restart at pixel 6
    for (int i = 0; i < 6; i++) apply(i, 0);
    run_frame(200);
    idle("s4");
    // sof without valid is ignored, then async reset after pixel 12
    for (int i = 0; i < 4; i++) apply(i, 0);
    in_sof = 1'b1;
    idle("s5 sof");
    in_sof = 1'b0;
    for (int i = 4; i < 13; i++) apply(i, 0);
    chk("pre-reset win8", int'(win[8]), 12);
    rst_n = 1'b0;
    #1;
    chk("async out_valid", int'(out_valid), 0);
    chk("async frame_done", int'(frame_done), 0);
    chk("async in_ready", int'(in_ready), 1);
    for (int k = 0; k < 9; k++) chk($sformatf("async win%0d", k), int'(win[k]), 0);
`ifdef CONV3X3_WINDOW_COORD_EN
    chk("async out_row", int'(out_row), 0);
    chk("async out_col", int'(out_col), 0);
`endif
    @(posedge clk); #1;
    rst_n = 1'b1;
    n0 = nx;
    run_frame(0);
    idle("s5");
    chk("s5 transfers", nx - n0, 4);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
